// File: rtl/kcu_axis_pkg.sv
// kcu_axis_pkg: shared AXI-Stream widths and the arbiter state encoding
package kcu_axis_pkg;
    localparam int AXIS_DATA_W = 512;
    localparam int AXIS_KEEP_W = AXIS_DATA_W / 8;
    typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_t;
endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: main register plus one overflow register; in_ready is overflow-empty
module axis_skid_buffer #(
    parameter int W = 8
) (
    input  logic         axi_aclk,
    input  logic         axi_areset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         ovf_valid;
    logic [W-1:0] ovf_data;
    assign in_ready = !ovf_valid;
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            ovf_valid <= 1'b0;
            ovf_data  <= '0;
        end else if (in_valid && in_ready) begin
            if (!out_valid || out_ready) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
            end else begin
                ovf_valid <= 1'b1;
                ovf_data  <= in_data;
            end
        end else if (out_ready) begin
            out_valid <= ovf_valid;
            out_data  <= ovf_valid ? ovf_data : out_data;
            ovf_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter: packet-locked round-robin arbiter onto one registered AXI-Stream master
module axis_pkt_arbiter
    import kcu_axis_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int DATA_W = AXIS_DATA_W,
    parameter int KEEP_W = DATA_W / 8,
    parameter int IDX_W  = N_IN > 1 ? $clog2(N_IN) : 1
) (
    input  logic                     axi_aclk,
    input  logic                     axi_areset,
    input  logic [N_IN-1:0]          cfg_en,
    input  logic [N_IN-1:0]          s_axis_tvalid,
    output logic [N_IN-1:0]          s_axis_tready,
    input  logic [N_IN*DATA_W-1:0]   s_axis_tdata,
    input  logic [N_IN*KEEP_W-1:0]   s_axis_tkeep,
    input  logic [N_IN-1:0]          s_axis_tlast,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [DATA_W-1:0]        m_axis_tdata,
    output logic [KEEP_W-1:0]        m_axis_tkeep,
    output logic                     m_axis_tlast,
    output logic [IDX_W-1:0]         grant_idx,
    output logic                     busy,
    output logic                     pkt_done
);
    arb_state_t       state;
    logic [IDX_W-1:0] rr_ptr, pick, cand;
    logic [N_IN-1:0]  req;
    logic             found, sk_ready, sk_valid, take, last_beat;
    assign req = s_axis_tvalid & cfg_en;
    always_comb begin
        pick  = rr_ptr;
        cand  = rr_ptr;
        found = 1'b0;
        for (int k = 0; k < N_IN; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % N_IN);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end
    assign sk_valid      = state == ARB_LOCK && s_axis_tvalid[grant_idx];
    assign take          = sk_valid && sk_ready;
    assign last_beat     = take && s_axis_tlast[grant_idx];
    assign busy          = state == ARB_LOCK;
    assign s_axis_tready = (state == ARB_LOCK && sk_ready) ? N_IN'(1) << grant_idx : '0;
    // grant is held from arbitration until the tlast beat is taken
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state     <= ARB_IDLE;
            grant_idx <= '0;
            rr_ptr    <= '0;
            pkt_done  <= 1'b0;
        end else begin
            pkt_done <= last_beat;
            if (state == ARB_IDLE && found) begin
                state     <= ARB_LOCK;
                grant_idx <= pick;
            end else if (last_beat) begin
                state  <= ARB_IDLE;
                rr_ptr <= grant_idx == IDX_W'(N_IN - 1) ? '0 : grant_idx + 1'b1;
            end
        end
    end
    axis_skid_buffer #(.W(DATA_W + KEEP_W + 1)) u_skid (
        .axi_aclk  (axi_aclk),
        .axi_areset(axi_areset),
        .in_valid  (sk_valid),
        .in_ready  (sk_ready),
        .in_data   ({s_axis_tlast[grant_idx],
                     s_axis_tkeep[int'(grant_idx) * KEEP_W +: KEEP_W],
                     s_axis_tdata[int'(grant_idx) * DATA_W +: DATA_W]}),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready),
        .out_data  ({m_axis_tlast, m_axis_tkeep, m_axis_tdata})
    );
endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// tb_axis_pkt_arbiter: randomized and directed checks against a queue-based model
module tb_axis_pkt_arbiter;
    localparam int N = 2, DW = 512, KW = 64, IW = 1;
    typedef struct packed {logic last; logic [KW-1:0] keep; logic [DW-1:0] data;} beat_t;
    logic            axi_aclk = 1'b0, axi_areset = 1'b1;
    logic [N-1:0]    cfg_en = 2'b11, s_axis_tvalid = '0, s_axis_tready, s_axis_tlast = '0;
    logic [N*DW-1:0] s_axis_tdata = '0;
    logic [N*KW-1:0] s_axis_tkeep = '0;
    logic            m_axis_tvalid, m_axis_tready = 1'b1, m_axis_tlast;
    logic [DW-1:0]   m_axis_tdata;
    logic [KW-1:0]   m_axis_tkeep;
    logic [IW-1:0]   grant_idx;
    logic            busy, pkt_done;

    axis_pkt_arbiter dut (
        .axi_aclk(axi_aclk), .axi_areset(axi_areset), .cfg_en(cfg_en),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .grant_idx(grant_idx), .busy(busy), .pkt_done(pkt_done)
    );

    always #5 axi_aclk = ~axi_aclk;

    int     nvec = 0, nerr = 0, cyc = 0, nlast = 0, mode = 0, vprob = 100;
    beat_t  q0[$], q1[$], sk[$];
    logic [N-1:0] pres = '0;
    logic   locked = 1'b0, pd = 1'b0, busy_q = 1'b0;
    int     g = 0, rr = 0;
    int     tags[$], gseq[$], pdt[$], diffs[$], expq[$];

    task automatic chk(string nm, logic [639:0] a, logic [639:0] e);
        nvec++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic chk_seq(string nm, int act[$], int exp[$]);
        chk({nm, "_len"}, act.size(), exp.size());
        if (act.size() == exp.size())
            foreach (exp[k]) chk(nm, act[k], exp[k]);
    endtask

    function automatic int qsz(int i);
        return i == 0 ? q0.size() : q1.size();
    endfunction

    function automatic beat_t front(int i);
        if (qsz(i) == 0) return '0;
        return i == 0 ? q0[0] : q1[0];
    endfunction

    task automatic push_pkt(int i, int id, int len);
        for (int b = 0; b < len; b++) begin
            beat_t x;
            x.data = {16{32'(id * 16 + b)}};
            x.keep = {$urandom(), $urandom()};
            x.last = b == len - 1;
            if (i == 0) q0.push_back(x); else q1.push_back(x);
        end
    endtask

    task automatic clr();
        tags.delete(); gseq.delete(); pdt.delete(); diffs.delete(); nlast = 0;
    endtask

    // compare at negedge, drive new inputs, then advance the model on the posedge
    task automatic tick();
        logic [N-1:0] etr;
        logic acc;
        beat_t b;
        etr = (locked && sk.size() < 2) ? 2'(1) << g : 2'b00;
        chk("s_axis_tready", s_axis_tready, etr);
        chk("m_axis_tvalid", m_axis_tvalid, sk.size() > 0);
        if (sk.size() > 0) begin
            chk("m_axis_tdata", m_axis_tdata, sk[0].data);
            chk("m_axis_tkeep", m_axis_tkeep, sk[0].keep);
            chk("m_axis_tlast", m_axis_tlast, sk[0].last);
        end
        chk("grant_idx", grant_idx, g);
        chk("busy", busy, locked);
        chk("pkt_done", pkt_done, pd);
        if (busy && !busy_q) gseq.push_back(int'(grant_idx));
        busy_q = busy;
        if (pkt_done) pdt.push_back(cyc);
        m_axis_tready = mode == 0 ? 1'b1 : mode == 1 ? !m_axis_tready : $urandom_range(99) < 70;
        if (m_axis_tvalid && m_axis_tready) begin
            tags.push_back(int'(m_axis_tdata[31:0]));
            if (m_axis_tlast) nlast++;
        end
        for (int i = 0; i < N; i++) begin
            beat_t f;
            if (!pres[i] && qsz(i) > 0 && $urandom_range(99) < vprob) pres[i] = 1'b1;
            f = pres[i] ? front(i) : '0;
            s_axis_tvalid[i] = pres[i];
            s_axis_tdata[i*DW +: DW] = f.data;
            s_axis_tkeep[i*KW +: KW] = f.keep;
            s_axis_tlast[i] = f.last;
        end
        @(posedge axi_aclk);
        if (axi_areset) begin
            locked = 0; g = 0; rr = 0; pd = 0;
            sk.delete(); q0.delete(); q1.delete(); pres = '0;
        end else begin
            acc = locked && s_axis_tvalid[g] && sk.size() < 2;
            b = acc ? front(g) : '0;
            if (sk.size() > 0 && m_axis_tready) void'(sk.pop_front());
            if (acc) begin
                sk.push_back(b);
                if (g == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                pres[g] = 1'b0;
            end
            pd = acc && b.last;
            if (!locked) begin
                for (int k = 0; k < N; k++)
                    if (!locked && s_axis_tvalid[(rr + k) % N] && cfg_en[(rr + k) % N]) begin
                        locked = 1;
                        g = (rr + k) % N;
                    end
            end else if (pd) begin
                locked = 0;
                rr = (g + 1) % N;
            end
        end
        cyc++;
        @(negedge axi_aclk);
    endtask

    task automatic drain(int budget);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || sk.size() > 0 || locked) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_within_budget", n < budget, 1'b1);
    endtask

    task automatic apply_reset();
        axi_areset = 1'b1;
        tick();
        axi_areset = 1'b0;
    endtask

    task automatic random_phase(int cycles);
        int ri;
        for (int c = 0; c < cycles; c++) begin
            if ($urandom_range(99) < 4) cfg_en = 2'($urandom_range(3));
            ri = $urandom_range(1);
            if ($urandom_range(99) < 15 && qsz(ri) < 12) push_pkt(ri, 32 + c, $urandom_range(4, 1));
            tick();
        end
    endtask

    initial begin
        repeat (3) @(posedge axi_aclk);
        @(negedge axi_aclk);
        axi_areset = 1'b0;
        chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_m_tdata", m_axis_tdata, '0);
        chk("rst_m_tkeep", m_axis_tkeep, '0);
        chk("rst_m_tlast", m_axis_tlast, 1'b0);
        chk("rst_s_tready", s_axis_tready, 2'b00);
        chk("rst_grant", grant_idx, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_pkt_done", pkt_done, 1'b0);

        // single 3-beat packet on input 0
        clr(); push_pkt(0, 1, 3); drain(50);
        expq = {32'h10, 32'h11, 32'h12};
        chk_seq("t1_tags", tags, expq);
        chk("t1_nlast", nlast, 1);
        chk("t1_pkt_done_cnt", pdt.size(), 1);
        chk("t1_grant", grant_idx, 1'b0);

        // two inputs with continuous 2-beat packets alternate
        apply_reset(); clr();
        push_pkt(0, 2, 2); push_pkt(0, 3, 2); push_pkt(1, 4, 2); push_pkt(1, 5, 2);
        drain(100);
        expq = {0, 1, 0, 1};
        chk_seq("t2_grants", gseq, expq);
        expq = {32'h20, 32'h21, 32'h40, 32'h41, 32'h30, 32'h31, 32'h50, 32'h51};
        chk_seq("t2_tags", tags, expq);

        // toggling downstream ready
        apply_reset(); clr(); mode = 1; push_pkt(0, 6, 4); drain(100); mode = 0;
        expq = {32'h60, 32'h61, 32'h62, 32'h63};
        chk_seq("t3_tags", tags, expq);

        // enable mask change mid-packet
        apply_reset(); clr(); cfg_en = 2'b01;
        push_pkt(0, 7, 4); push_pkt(1, 8, 2);
        repeat (3) tick();
        cfg_en = 2'b10;
        drain(100);
        cfg_en = 2'b11;
        expq = {0, 1};
        chk_seq("t4_grants", gseq, expq);
        expq = {32'h70, 32'h71, 32'h72, 32'h73, 32'h80, 32'h81};
        chk_seq("t4_tags", tags, expq);

        // reset in the middle of a packet restores the pointer
        apply_reset(); clr();
        push_pkt(0, 9, 1); drain(50);
        push_pkt(1, 10, 4);
        repeat (3) tick();
        apply_reset();
        chk("t5_m_tvalid", m_axis_tvalid, 1'b0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_s_tready", s_axis_tready, 2'b00);
        clr();
        push_pkt(0, 11, 1); push_pkt(1, 12, 1); drain(50);
        expq = {0, 1};
        chk_seq("t5_grants", gseq, expq);
        expq = {32'hb0, 32'hc0};
        chk_seq("t5_tags", tags, expq);

        // back-to-back single-beat packets on input 1
        clr();
        for (int k = 0; k < 5; k++) push_pkt(1, 13 + k, 1);
        drain(60);
        for (int k = 1; k < pdt.size(); k++) diffs.push_back(pdt[k] - pdt[k-1]);
        expq = {2, 2, 2, 2};
        chk_seq("t6_pkt_done_gap", diffs, expq);
        expq = {32'hd0, 32'he0, 32'hf0, 32'h100, 32'h110};
        chk_seq("t6_tags", tags, expq);

        // randomized traffic, masks and backpressure
        apply_reset(); clr(); mode = 2; vprob = 70;
        random_phase(3000);
        cfg_en = 2'b11; mode = 0; vprob = 100;
        drain(500);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
